// File: rtl/tt_um_result_collect.sv
// Deserialises LSB-first bit-serial lane results into words, buffers two frames (ping-pong)
// and drains them over valid/ready. Optional macro RESULT_COLLECT_SIGNED_EN adds out_sat.
module tt_um_result_collect #(
    parameter int MAX_OUT_LEN = 4,
    parameter int BIT_WIDTH   = 8,
    parameter int FRAME_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [2:0]                     in_bit_select,
    input  logic [MAX_OUT_LEN-1:0]         in_bits,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [BIT_WIDTH-1:0]           out_data,
    output logic [$clog2(MAX_OUT_LEN)-1:0] out_lane,
    output logic                           out_last,
`ifdef RESULT_COLLECT_SIGNED_EN
    output logic                           out_sat,
`endif
    output logic                           overflow,
    output logic                           sync_err
);

    localparam int LW = $clog2(MAX_OUT_LEN);
    localparam int CW = $clog2(FRAME_DEPTH + 1);
    localparam logic [2:0]    LAST_BIT  = 3'(BIT_WIDTH - 1);
    localparam logic [LW-1:0] LAST_LANE = LW'(MAX_OUT_LEN - 1);

    typedef enum logic {HUNT, COLLECT} state_t;

    state_t               r_state, w_next;
    logic [2:0]           r_expected;
    logic [BIT_WIDTH-1:0] r_shift [MAX_OUT_LEN];
    logic [BIT_WIDTH-1:0] r_buf   [2][MAX_OUT_LEN];
    logic [BIT_WIDTH-1:0] w_frame [MAX_OUT_LEN];
    logic                 r_rd_sel;
    logic [CW-1:0]        r_cnt;
    logic [LW-1:0]        r_lane;
    logic                 r_overflow, r_sync_err;

    logic w_start, w_accept, w_err, w_complete;
    logic w_pop, w_pop_last, w_full, w_push, w_drop, w_wr_sel;

`ifdef RESULT_COLLECT_SIGNED_EN
    function automatic logic is_min_neg(input logic signed [BIT_WIDTH-1:0] v);
        logic signed [BIT_WIDTH-1:0] min_neg;
        min_neg = {1'b1, {(BIT_WIDTH-1){1'b0}}};
        return v == min_neg;
    endfunction
`endif

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_accept   = 1'b0;
        w_err      = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            HUNT: begin
                if (in_valid && in_bit_select == 3'd0) begin
                    w_start = 1'b1;
                    w_next  = COLLECT;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    if (in_bit_select == r_expected) begin
                        w_accept = 1'b1;
                        if (r_expected == LAST_BIT) begin
                            w_complete = 1'b1;
                            w_next     = HUNT;
                        end
                    end else begin
                        // A fresh bit 0 restarts capture on the spot instead of losing a frame
                        w_err = 1'b1;
                        if (in_bit_select == 3'd0) w_start = 1'b1;
                        else                       w_next  = HUNT;
                    end
                end
            end
            default: w_next = HUNT;
        endcase
    end

    assign w_pop      = out_valid && out_ready;
    assign w_pop_last = w_pop && out_last;
    assign w_full     = (r_cnt == CW'(FRAME_DEPTH));
    assign w_push     = w_complete && (!w_full || w_pop_last);
    assign w_drop     = w_complete && !w_push;
    // With one frame held the other slot is free; otherwise the oldest slot is (or is being) freed
    assign w_wr_sel   = (r_cnt == CW'(1)) ? ~r_rd_sel : r_rd_sel;

    always_comb begin
        for (int k = 0; k < MAX_OUT_LEN; k++)
            w_frame[k] = {in_bits[k], r_shift[k][BIT_WIDTH-2:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= HUNT;
            r_expected <= 3'd0;
            for (int k = 0; k < MAX_OUT_LEN; k++) r_shift[k] <= '0;
            r_cnt      <= '0;
            r_rd_sel   <= 1'b0;
            r_lane     <= '0;
            r_overflow <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_expected <= 3'd1;
                for (int k = 0; k < MAX_OUT_LEN; k++) r_shift[k] <= BIT_WIDTH'(in_bits[k]);
            end else if (w_accept) begin
                r_expected <= r_expected + 3'd1;
                for (int k = 0; k < MAX_OUT_LEN; k++) r_shift[k][r_expected] <= in_bits[k];
            end
            case ({w_push, w_pop_last})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (w_pop_last) r_rd_sel <= ~r_rd_sel;
            if (w_pop)      r_lane   <= w_pop_last ? '0 : r_lane + LW'(1);
            if (w_drop)     r_overflow <= 1'b1;
            if (w_err)      r_sync_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            for (int k = 0; k < MAX_OUT_LEN; k++) r_buf[w_wr_sel][k] <= w_frame[k];
    end

    assign out_valid = (r_cnt != '0);
    assign out_lane  = r_lane;
    assign out_last  = out_valid && (r_lane == LAST_LANE);
    assign out_data  = out_valid ? r_buf[r_rd_sel][r_lane] : '0;
    assign overflow  = r_overflow;
    assign sync_err  = r_sync_err;
`ifdef RESULT_COLLECT_SIGNED_EN
    assign out_sat   = out_valid && is_min_neg(out_data);
`endif

endmodule

// File: tb/tb_tt_um_result_collect.sv
// Testbench for tt_um_result_collect: table-driven frames plus hand-written corner sequences,
// with a word scoreboard compared at every output handshake.
module tb_tt_um_result_collect;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_bit_select = 3'd0;
    logic [3:0] in_bits = 4'd0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_lane;
    logic       out_last;
    logic       overflow;
    logic       sync_err;
`ifdef RESULT_COLLECT_SIGNED_EN
    logic       out_sat;
`endif

    tt_um_result_collect #(.MAX_OUT_LEN(4), .BIT_WIDTH(8), .FRAME_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit_select(in_bit_select),
        .in_bits(in_bits), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_lane(out_lane), .out_last(out_last),
`ifdef RESULT_COLLECT_SIGNED_EN
        .out_sat(out_sat),
`endif
        .overflow(overflow), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] lane;
        logic       last;
    } exp_t;

    typedef struct packed {
        logic [31:0] lanes;
        logic [31:0] exp_words;
    } vec_t;

    exp_t q[$];
    vec_t tab[4];
    int   n_checks = 0;
    int   n_errs   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_word: got lane %0d data %0h expected no word", out_lane, out_data);
            end else begin
                e = q.pop_front();
                chk("word_data", out_data, e.d);
                chk("word_lane", out_lane, e.lane);
                chk("word_last", out_last, e.last);
`ifdef RESULT_COLLECT_SIGNED_EN
                chk("word_sat", out_sat, e.d == 8'h80);
`endif
            end
        end
    end

    task automatic push_exp(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.d    = w[8*k +: 8];
            e.lane = 2'(k);
            e.last = (k == 3);
            q.push_back(e);
        end
    endtask

    task automatic send_frame(input logic [31:0] lanes, input int pause_after, input int ready_at);
        for (int b = 0; b < 8; b++) begin
            @(posedge clk); #1;
            in_valid      = 1'b1;
            in_bit_select = 3'(b);
            for (int k = 0; k < 4; k++) in_bits[k] = lanes[8*k + b];
            if (b == ready_at) out_ready = 1'b1;
            if (b == pause_after) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drive_bit(input logic [2:0] s, input logic [3:0] b);
        @(posedge clk); #1;
        in_valid      = 1'b1;
        in_bit_select = s;
        in_bits       = b;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk); #1;
            if (q.size() == 0 && !out_valid) done = 1'b1;
        end
        chk("drain_done", done, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        tab[0] = '{32'h80FF015A, 32'h80FF015A};
        tab[1] = '{32'h33333333, 32'h33333333};
        tab[2] = '{32'h00FF7F81, 32'h00FF7F81};
        tab[3] = '{32'hA5C3E718, 32'hA5C3E718};

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_lane", out_lane, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_sync_err", sync_err, 0);
        rst = 1'b0;

        // Table of clean frames drained with ready held high
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b1;
            push_exp(tab[i].exp_words);
            send_frame(tab[i].lanes, -1, -1);
            if (i == 0) begin
                @(negedge clk);
                chk("latency_valid", out_valid, 1);
            end
            wait_drain(20);
        end
        chk("table_overflow", overflow, 0);
        chk("table_sync_err", sync_err, 0);

        // Backpressure: A and B buffered, C dropped
        do_reset();
        push_exp(32'h44332211);
        send_frame(32'h44332211, -1, -1);
        push_exp(32'h88776655);
        send_frame(32'h88776655, -1, -1);
        send_frame(32'hDDCCBBAA, -1, -1);
        @(negedge clk);
        chk("ovf_flag", overflow, 1);
        chk("ovf_valid", out_valid, 1);
        chk("ovf_lane", out_lane, 0);
        chk("ovf_data", out_data, 8'h11);
        repeat (3) @(negedge clk);
        chk("stall_data", out_data, 8'h11);
        chk("stall_last", out_last, 0);
        out_ready = 1'b1;
        wait_drain(30);

        // Sync error: 0,1,2,5 then a clean frame
        do_reset();
        out_ready = 1'b1;
        drive_bit(3'd0, 4'hF);
        drive_bit(3'd1, 4'hF);
        drive_bit(3'd2, 4'hF);
        drive_bit(3'd5, 4'hF);
        idle();
        @(negedge clk);
        chk("sync_flag", sync_err, 1);
        chk("sync_no_push", out_valid, 0);
        push_exp(32'h33333333);
        send_frame(32'h33333333, -1, -1);
        wait_drain(20);
        chk("sync_overflow", overflow, 0);

        // Pause after bit 3
        do_reset();
        out_ready = 1'b1;
        push_exp(32'hC96E2B17);
        send_frame(32'hC96E2B17, 3, -1);
        wait_drain(20);
        chk("pause_sync_err", sync_err, 0);

        // Bit 0 arriving while bit 4 is expected restarts capture
        do_reset();
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) drive_bit(3'(b), 4'h5);
        push_exp(32'h0F1E2D3C);
        send_frame(32'h0F1E2D3C, -1, -1);
        wait_drain(20);
        chk("restart_sync_err", sync_err, 1);

        // Final pop of A on the same edge as C's last bit
        do_reset();
        push_exp(32'h04030201);
        send_frame(32'h04030201, -1, -1);
        push_exp(32'h08070605);
        send_frame(32'h08070605, -1, -1);
        push_exp(32'h0C0B0A09);
        send_frame(32'h0C0B0A09, -1, 4);
        wait_drain(40);
        chk("simul_overflow", overflow, 0);

        // Async reset in the middle of a drain
        do_reset();
        push_exp(32'h44332211);
        send_frame(32'h44332211, -1, -1);
        push_exp(32'h88776655);
        send_frame(32'h88776655, -1, -1);
        send_frame(32'hDDCCBBAA, -1, -1);
        drive_bit(3'd0, 4'h0);
        drive_bit(3'd3, 4'h0);
        idle();
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("pre_rst_lane", out_lane, 1);
        chk("pre_rst_overflow", overflow, 1);
        chk("pre_rst_sync_err", sync_err, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_overflow", overflow, 0);
        chk("arst_sync_err", sync_err, 0);
        chk("arst_lane", out_lane, 0);
        q.delete();
        #1 rst = 1'b0;
        out_ready = 1'b1;
        push_exp(32'h7E5D3C1B);
        send_frame(32'h7E5D3C1B, -1, -1);
        wait_drain(20);

        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/tt_um_result_collect.md
Name: tt_um_result_collect

Overview:
- Downstream stage of the ternary multiply block.
- The multiply block emits one bit per output lane per cycle, LSB first, indexed by a 3-bit bit-select.
- This block deserialises those bits into MAX_OUT_LEN words of BIT_WIDTH bits each and buffers up to two complete frames.
- It drains buffered words one per handshake over a valid/ready interface, toward the output pins or a host-read shifter.

Parameters:
- MAX_OUT_LEN, 4: number of output lanes, i.e. words per frame.
- BIT_WIDTH, 8: bits per word; also the number of bit-serial cycles per frame (power of 2, max 8).
- FRAME_DEPTH, 2: number of complete frames buffered (fixed at 2; ping-pong).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  multiply stage in MULT phase; bits are valid this cycle.
- in_bit_select  input  3  bit index of in_bits (0 = LSB).
- in_bits  input  MAX_OUT_LEN  one result bit per lane.
- out_valid  output  1  a buffered word is presented.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  BIT_WIDTH  presented word.
- out_lane  output  clog2(MAX_OUT_LEN)  lane index of out_data.
- out_last  output  1  out_data is the last lane of its frame.
- overflow  output  1  sticky: a completed frame was dropped.
- sync_err  output  1  sticky: bit-select sequence broken.

Behaviour:
- Reset (async, rst=1): all outputs 0, both buffers empty, collect FSM in HUNT, shift registers 0. Stickies clear only on reset.
- Collect FSM states: HUNT, COLLECT.
  - HUNT: ignore input until in_valid=1 and in_bit_select=0. On that cycle, capture bit 0 of every lane, set expected=1, go to COLLECT.
  - COLLECT, in_valid=1 and in_bit_select==expected: lane k bit[expected] <= in_bits[k]; expected increments.
  - COLLECT, in_valid=1 and in_bit_select!=expected: set sync_err, discard the partial frame. If in_bit_select==0, restart capture immediately (stay in COLLECT, expected=1); otherwise go to HUNT.
  - COLLECT, in_valid=0: hold; the frame pauses without error.
  - Frame completes when bit BIT_WIDTH-1 is accepted.
- Frame push: on completion, the assembled frame (with the final bit merged) is written into the free buffer at that edge; FSM returns to HUNT.
  - If both buffers are full and no final pop occurs that cycle: frame dropped, overflow set, buffers unchanged.
  - Simultaneous push and final pop (out_valid & out_ready & out_last) while full: push accepted.
- Drain:
  - out_valid=1 whenever a buffer is full.
  - Words go out oldest frame first, lanes 0..MAX_OUT_LEN-1.
  - Word advances on out_valid & out_ready.
  - out_last=1 on lane MAX_OUT_LEN-1. Its handshake frees that buffer and resets out_lane to 0.
  - out_data, out_lane and out_last are stable while out_valid=1 and out_ready=0.
- Latency: out_valid rises the cycle after the edge that captures bit BIT_WIDTH-1, when the buffers were previously empty. With out_ready held high, a full frame drains in MAX_OUT_LEN cycles.
- Throughput: BIT_WIDTH ≥ MAX_OUT_LEN, so continuous drain never overflows.
- Reset mid-frame or mid-drain: everything is discarded immediately and the block returns to the reset state.

Optional Feature:
- Macro: RESULT_COLLECT_SIGNED_EN.
- Defined:
  - Each word is interpreted as two's complement.
  - Adds output port out_sat (1 bit), asserted with a word whose value is -2^(BIT_WIDTH-1) (e.g. 0x80). This flags a possible accumulator wrap.
  - out_sat is 0 when out_valid=0 and 0 at reset.
- Not defined: port absent; words are raw unsigned bit patterns.

Test Plan:
- Basic frame: reset; drive in_valid=1, bit_select 0..7 with lane values 0x5A, 0x01, 0xFF, 0x80 (LSB first), out_ready=1 → out_valid rises next cycle; out_data 0x5A, 0x01, 0xFF, 0x80 on lanes 0..3 in 4 consecutive cycles; out_last only on lane 3.
- Backpressure/overflow: out_ready=0, push three frames A, B, C → A and B buffered, C dropped, overflow=1. Raise out_ready → A's 4 words then B's, out_valid falls after B lane 3.
- Sync error: bit_select 0,1,2,5 → sync_err=1, FSM to HUNT, no push. Then a clean 0..7 frame with 0x33 in all lanes → four words of 0x33.
- Pause/restart: in_valid drops for 3 cycles after bit 3 → no error, frame completes correctly. Separately, bit 0 arriving at expected=4 → sync_err=1 and the new frame is collected.
- Full push with simultaneous pop: both buffers full; final pop of frame A on the same edge as frame C's last bit → no overflow, drain order B then C.
- Async reset: assert rst mid-drain (lane 1) between clock edges → out_valid, overflow and sync_err go 0 immediately; the next clean frame drains from lane 0.
